apb2up_bridge: RTL and testbench
================================

// Module: apb2up_bridge
// PURPOSE
//  APB3 slave to up-protocol master bridge; sits directly upstream of the up_ramcfg_* macros
//  and drives their upen/upa/upws/uprs/updi, consuming updo/uprdy. One outstanding access.
//  Issues single-cycle write/read strobes, holds upen until uprdy or timeout, and returns
//  pready/prdata/pslverr. Timeout drops upen, which clears the macro's pending-read latch.
// PARAMETERS
//  G_ADDR   10   up word-address width (upa)
//  G_WIDTH  32   data width (pwdata/prdata/updi/updo)
//  G_PADDR  32   APB byte-address width; must be >= G_ADDR+2
//  G_TMO    256  max WAIT cycles before timeout; legal range 2..65535
// PORTS
//  clk      in   1        single clock
//  rst      in   1        synchronous reset, active high
//  psel     in   1        APB select
//  penable  in   1        APB access phase
//  pwrite   in   1        1 = write, 0 = read
//  paddr    in   G_PADDR  APB byte address
//  pwdata   in   G_WIDTH  APB write data
//  prdata   out  G_WIDTH  APB read data, valid while pready=1
//  pready   out  1        APB transfer complete, one-cycle pulse
//  pslverr  out  1        APB error, valid only with pready
//  upen     out  1        up access enable, held for whole access
//  upa      out  G_ADDR   up word address = paddr[G_ADDR+1:2]
//  upws     out  1        up write strobe, one cycle
//  uprs     out  1        up read strobe, one cycle
//  updi     out  G_WIDTH  up write data
//  updo     in   G_WIDTH  up read data, valid with uprdy
//  uprdy    in   1        up access done
// BEHAVIOUR
//  - One clock, synchronous active-high rst. All outputs are flops or Moore decodes of state.
//  - Reset value: every output 0; state IDLE; timeout counter 0. rst mid-access aborts at
//    next edge: upen drops, no pready is issued for the aborted transfer.
//  - States: IDLE, REQ, WAIT, RESP.
//    IDLE: on psel&penable: capture pwrite/upa/updi. If paddr[1:0]!=0 or
//      paddr[G_PADDR-1:G_ADDR+2]!=0 -> RESP with err=1, no up access. Otherwise -> REQ.
//    REQ (1 cycle): upen=1, upws=pwrite, uprs=!pwrite -> WAIT; counter cleared.
//    WAIT: upen=1, strobes 0. uprdy=1 -> RESP, err=0, prdata<=updo on reads (0 on writes).
//      Counter reaches G_TMO-1 without uprdy -> RESP, err=1, prdata=0.
//    RESP (1 cycle): upen=0, pready=1, pslverr=err -> IDLE.
//  - Latency, uprdy returned one cycle after the strobe: APB access cycle at N, REQ N+1,
//    uprdy seen N+2, pready at N+3. Read extends by N stall cycles if up_ramcfg arbitration
//    stalls the read for N cycles; uprdy is honoured in any WAIT cycle.
//  - upa/updi stay stable from REQ through WAIT; they hold their last value in IDLE/RESP.
//  - uprdy in IDLE, REQ or RESP is ignored: stray, no state change.
//  - psel without penable: no action. APB signals are not sampled outside IDLE.
//  - RESP->IDLE forces one idle cycle between accesses, so upen deasserts for >=1 cycle
//    between consecutive up accesses.
//  - uprdy arriving on the same edge as timeout: uprdy wins (err=0, data captured).
// STRUCTURE
//  - Shared package: state encoding constants (IDLE/REQ/WAIT/RESP) and a clog2 function
//    that sizes the timeout counter from G_TMO.
//  - One sub-module, apb2up_tmo: sync-clear, enable, terminal-count counter, output is
//    tmo_hit. Everything else is flat in this module.
// TESTING
//  1. Write paddr=0x0000_0010, pwdata=0xDEAD_BEEF, uprdy 1 cycle after REQ -> one-cycle
//     upws with upa=0x004, updi=0xDEADBEEF; pready at N+3, pslverr=0.
//  2. Read paddr=0x0FFC, updo=0x1234_5678 with uprdy after 3 WAIT cycles -> uprs one cycle,
//     upa=0x3FF, prdata=0x12345678, pready one cycle later, pslverr=0.
//  3. Read with uprdy never asserted, G_TMO=4 -> upen high for REQ plus 4 WAIT cycles, then
//     drops; pready=1, pslverr=1, prdata=0.
//  4. paddr=0x0000_1000 (above G_ADDR=10) and paddr=0x0000_0002 (unaligned) -> upen never
//     rises; pready next cycle with pslverr=1.
//  5. rst pulsed during WAIT -> all outputs 0 next edge, no pready. Next write then completes
//     normally.
//  6. Back-to-back writes, APB setup cycle immediately after pready -> upen low >=1 cycle
//     between accesses; exactly one upws per transfer. Stray uprdy in IDLE is ignored.

Source files
------------

// File: rtl/apb2up_bridge_pkg.sv
// Shared definitions for the APB-to-up bridge.
//   state_e : FSM state encoding (IDLE/REQ/WAIT/RESP)
//   clog2   : ceiling log2, used to size the timeout counter from G_TMO
package apb2up_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/apb2up_bridge_tmo.sv
// Timeout counter for the bridge WAIT state.
//   clk       : clock
//   rst       : synchronous reset, active high
//   clr_i     : synchronous clear (asserted while the bridge is in REQ)
//   en_i      : count enable (asserted while the bridge is in WAIT)
//   tmo_hit_o : high in an enabled cycle where the count has reached G_TMO-1
module apb2up_tmo
  import apb2up_bridge_pkg::*;
#(
  parameter int G_TMO = 256,
  parameter int CW    = clog2(G_TMO)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tmo_hit_o
);

  localparam logic [CW-1:0] TERM = CW'(G_TMO - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter parks at the terminal value so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo_hit_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/apb2up_bridge.sv
// APB3 slave to up-protocol master bridge, one outstanding access.
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata            : APB request inputs (sampled in IDLE only)
//   prdata, pready,
//   pslverr           : APB response; pready is a one-cycle pulse
//   upen, upa, upws,
//   uprs, updi        : up-side request; upen held for the whole access
//   updo, uprdy       : up-side completion
//   dbg_state         : current FSM state (apb2up_bridge_pkg::state_e encoding)
//
// Handshake: an APB access is accepted when psel&penable is seen in IDLE; the
// bridge answers with a single pready cycle in RESP, after which the master
// must drop penable. On the up side a single-cycle upws/uprs opens the access,
// upen stays high until uprdy (honoured only in WAIT) or timeout.
module apb2up_bridge
  import apb2up_bridge_pkg::*;
#(
  parameter int G_ADDR  = 10,
  parameter int G_WIDTH = 32,
  parameter int G_PADDR = 32,
  parameter int G_TMO   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [G_PADDR-1:0] paddr,
  input  logic [G_WIDTH-1:0] pwdata,
  output logic [G_WIDTH-1:0] prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               upen,
  output logic [G_ADDR-1:0]  upa,
  output logic               upws,
  output logic               uprs,
  output logic [G_WIDTH-1:0] updi,
  input  logic [G_WIDTH-1:0] updo,
  input  logic               uprdy,
  output logic [1:0]         dbg_state
);

  state_e             state_q, state_d;
  logic               err_q, err_d;
  logic               pwrite_q, pwrite_d;
  logic [G_ADDR-1:0]  upa_q, upa_d;
  logic [G_WIDTH-1:0] updi_q, updi_d;
  logic [G_WIDTH-1:0] prdata_q, prdata_d;
  logic               tmo_hit;
  logic               addr_bad;

  // Address must be word aligned and fit inside the up word-address space.
  assign addr_bad = (paddr[1:0] != 2'b00) || (|(paddr >> (G_ADDR + 2)));

  apb2up_tmo #(
    .G_TMO (G_TMO)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == S_REQ),
    .en_i      (state_q == S_WAIT),
    .tmo_hit_o (tmo_hit)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    pwrite_d = pwrite_q;
    upa_d    = upa_q;
    updi_d   = updi_q;
    prdata_d = prdata_q;
    case (state_q)
      S_IDLE: begin
        if (psel && penable) begin
          pwrite_d = pwrite;
          upa_d    = paddr[G_ADDR+1:2];
          updi_d   = pwdata;
          if (addr_bad) begin
            err_d    = 1'b1;
            prdata_d = '0;
            state_d  = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // uprdy is checked first so it wins over a same-cycle timeout.
        if (uprdy) begin
          err_d    = 1'b0;
          prdata_d = pwrite_q ? '0 : updo;
          state_d  = S_RESP;
        end else if (tmo_hit) begin
          err_d    = 1'b1;
          prdata_d = '0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      pwrite_q <= 1'b0;
      upa_q    <= '0;
      updi_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      pwrite_q <= pwrite_d;
      upa_q    <= upa_d;
      updi_q   <= updi_d;
      prdata_q <= prdata_d;
    end
  end

  // Moore decodes of the registered state.
  assign upen      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign upws      = (state_q == S_REQ) && pwrite_q;
  assign uprs      = (state_q == S_REQ) && !pwrite_q;
  assign pready    = (state_q == S_RESP);
  assign pslverr   = (state_q == S_RESP) && err_q;
  assign prdata    = prdata_q;
  assign upa       = upa_q;
  assign updi      = updi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb2up_bridge.sv
module tb_apb2up_bridge;

  localparam int G_ADDR  = 10;
  localparam int G_WIDTH = 32;
  localparam int G_PADDR = 32;
  localparam int G_TMO   = 4;

  logic               clk;
  logic               rst;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [G_PADDR-1:0] paddr;
  logic [G_WIDTH-1:0] pwdata;
  logic [G_WIDTH-1:0] prdata;
  logic               pready;
  logic               pslverr;
  logic               upen;
  logic [G_ADDR-1:0]  upa;
  logic               upws;
  logic               uprs;
  logic [G_WIDTH-1:0] updi;
  logic [G_WIDTH-1:0] updo;
  logic               uprdy;
  logic               uprdy_rsp;
  logic               uprdy_stray;
  logic [1:0]         dbg_state;

  assign uprdy = uprdy_rsp | uprdy_stray;

  apb2up_bridge #(
    .G_ADDR  (G_ADDR),
    .G_WIDTH (G_WIDTH),
    .G_PADDR (G_PADDR),
    .G_TMO   (G_TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .upen      (upen),
    .upa       (upa),
    .upws      (upws),
    .uprs      (uprs),
    .updi      (updi),
    .updo      (updo),
    .uprdy     (uprdy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [G_WIDTH:0]          exp_q[$];     // {pslverr, prdata}
  logic [G_ADDR+G_WIDTH:0]   exp_up_q[$];  // {write, upa, updi}

  int               rsp_delay = 0;        // WAIT cycles before uprdy, -1 = never
  logic [G_WIDTH-1:0] rsp_data = '0;
  int               upen_cnt = 0;
  int               upws_cnt = 0;
  int               uprs_cnt = 0;
  logic [G_ADDR-1:0]  last_upa = '0;
  logic [G_WIDTH-1:0] last_updi = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB response monitor ----------------
  logic [G_WIDTH:0] apb_exp;
  always @(negedge clk) begin
    if (pready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pready", 64'd1, 64'd0);
      end else begin
        apb_exp = exp_q.pop_front();
        check("pslverr", 64'(pslverr), 64'(apb_exp[G_WIDTH]));
        check("prdata", 64'(prdata), 64'(apb_exp[G_WIDTH-1:0]));
      end
    end
  end

  // ---------------- up-side monitor ----------------
  logic [G_ADDR+G_WIDTH:0] up_exp;
  always @(negedge clk) begin
    if (upen) upen_cnt++;
    if (upws) upws_cnt++;
    if (uprs) uprs_cnt++;
    if (upws || uprs) begin
      if (exp_up_q.size() == 0) begin
        check("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        up_exp = exp_up_q.pop_front();
        check("strobe_kind", 64'({upws, uprs}),
              64'({up_exp[G_ADDR+G_WIDTH], !up_exp[G_ADDR+G_WIDTH]}));
        check("upa", 64'(upa), 64'(up_exp[G_ADDR+G_WIDTH-1:G_WIDTH]));
        check("updi", 64'(updi), 64'(up_exp[G_WIDTH-1:0]));
        last_upa  = up_exp[G_ADDR+G_WIDTH-1:G_WIDTH];
        last_updi = up_exp[G_WIDTH-1:0];
      end
    end
    if (uprdy_rsp && upen) begin
      check("upa_hold", 64'(upa), 64'(last_upa));
      check("updi_hold", 64'(updi), 64'(last_updi));
    end
  end

  // ---------------- up-side responder ----------------
  initial begin
    uprdy_rsp = 1'b0;
    updo      = '0;
    forever begin
      @(negedge clk);
      if ((upws || uprs) && rsp_delay >= 0) begin
        @(posedge clk); #1;
        repeat (rsp_delay) begin
          @(posedge clk); #1;
        end
        uprdy_rsp = 1'b1;
        updo      = rsp_data;
        @(posedge clk); #1;
        uprdy_rsp = 1'b0;
        updo      = '0;
      end
    end
  end

  // ---------------- APB driver ----------------
  task automatic apb_xfer(
    input bit                 wr,
    input logic [G_PADDR-1:0] addr,
    input logic [G_WIDTH-1:0] data,
    input int                 delay,
    input bit                 exp_err,
    input logic [G_WIDTH-1:0] exp_rdata,
    input logic [G_ADDR-1:0]  exp_upa,
    input int                 exp_lat,
    input int                 exp_upen,
    input bit                 in_setup = 1'b0,
    input bit                 chain = 1'b0,
    input bit                 nx_wr = 1'b0,
    input logic [G_PADDR-1:0] nx_addr = '0,
    input logic [G_WIDTH-1:0] nx_data = '0
  );
    int lat;
    rsp_delay = delay;
    rsp_data  = wr ? 32'hA5A5_A5A5 : exp_rdata;
    exp_q.push_back({exp_err, exp_rdata});
    if (exp_upen > 0) exp_up_q.push_back({wr, exp_upa, data});
    if (!in_setup) begin
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    end
    @(posedge clk); #1;
    penable  = 1'b1;
    upen_cnt = 0;
    upws_cnt = 0;
    uprs_cnt = 0;
    lat      = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (pready) break;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("upen_cycles", 64'(upen_cnt), 64'(exp_upen));
    check("upws_count", 64'(upws_cnt), 64'((exp_upen > 0 && wr) ? 1 : 0));
    check("uprs_count", 64'(uprs_cnt), 64'((exp_upen > 0 && !wr) ? 1 : 0));
    @(posedge clk); #1;
    if (chain) begin
      psel = 1'b1; penable = 1'b0; pwrite = nx_wr; paddr = nx_addr; pwdata = nx_data;
    end else begin
      psel = 1'b0; penable = 1'b0;
    end
    @(negedge clk);
    check("gap_upen", 64'(upen), 64'd0);
    check("gap_pready", 64'(pready), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    uprdy_stray = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_upen", 64'(upen), 64'd0);
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_pslverr", 64'(pslverr), 64'd0);
    check("rst_prdata", 64'(prdata), 64'd0);
    check("rst_strobes", 64'({upws, uprs}), 64'd0);
    check("rst_upa", 64'(upa), 64'd0);
    check("rst_updi", 64'(updi), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. write, uprdy in first WAIT cycle
    apb_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 10'h004, 4, 2);

    // 2. read with three stall cycles; uprdy lands on the timeout cycle and wins
    apb_xfer(1'b0, 32'h0000_0FFC, 32'h0, 3, 1'b0, 32'h1234_5678, 10'h3FF, 7, 5);

    // 3. read, uprdy never arrives -> REQ + 4 WAIT, then error
    apb_xfer(1'b0, 32'h0000_0020, 32'h0, -1, 1'b1, 32'h0, 10'h008, 7, 5);

    // 4. out-of-range and unaligned addresses -> immediate error, no up access
    apb_xfer(1'b1, 32'h0000_1000, 32'h1111_2222, 0, 1'b1, 32'h0, 10'h000, 2, 0);
    apb_xfer(1'b0, 32'h0000_0002, 32'h0, 0, 1'b1, 32'h0, 10'h000, 2, 0);

    // 5. reset during WAIT aborts with no pready, next write completes
    rsp_delay = -1;
    exp_up_q.push_back({1'b1, 10'h010, 32'h5555_AAAA});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0040; pwdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;             // REQ cycle
    @(posedge clk); #1;             // first WAIT cycle
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("wait_upen", 64'(upen), 64'd1);
    check("wait_state", 64'(dbg_state), 64'd2);
    @(negedge clk);
    check("abort_upen", 64'(upen), 64'd0);
    check("abort_pready", 64'(pready), 64'd0);
    check("abort_pslverr", 64'(pslverr), 64'd0);
    check("abort_strobes", 64'({upws, uprs}), 64'd0);
    check("abort_upa", 64'(upa), 64'd0);
    check("abort_updi", 64'(updi), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    apb_xfer(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 10'h011, 4, 2);

    // 6. back-to-back writes with setup in the cycle right after pready
    apb_xfer(1'b1, 32'h0000_0008, 32'h1111_1111, 0, 1'b0, 32'h0, 10'h002, 4, 2,
             1'b0, 1'b1, 1'b1, 32'h0000_000C, 32'h2222_2222);
    apb_xfer(1'b1, 32'h0000_000C, 32'h2222_2222, 0, 1'b0, 32'h0, 10'h003, 4, 2, 1'b1);

    // stray uprdy while idle must be ignored
    @(posedge clk); #1;
    uprdy_stray = 1'b1;
    @(posedge clk); #1;
    uprdy_stray = 1'b0;
    @(negedge clk);
    check("stray_state", 64'(dbg_state), 64'd0);
    check("stray_upen", 64'(upen), 64'd0);
    check("stray_pready", 64'(pready), 64'd0);

    repeat (3) @(posedge clk);
    check("apb_queue_empty", 64'(exp_q.size()), 64'd0);
    check("up_queue_empty", 64'(exp_up_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
